// File: rtl/imem_boot_loader_if.sv
// Boot stream (valid/ready) plus instruction-store write port shared by the
// boot link, the loader and the instruction store.
interface imem_boot_loader_if;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        mem_we;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready,
      input  mem_we,
      input  mem_waddr,
      input  mem_wdata
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready,
      output mem_we,
      output mem_waddr,
      output mem_wdata
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Fills the instruction store from a valid/ready word stream, then pulses
// pc_reset and drops cpu_stall so the core starts fetching from address 0.
module imem_boot_loader #(
   parameter int DEPTH         = 64,
   parameter bit HOLD_AT_RESET = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [$clog2(DEPTH):0] num_words,
   imem_boot_loader_if.slave      bus,
   output logic                   cpu_stall,
   output logic                   pc_reset,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] widx;
   logic [CNT_W-1:0] remaining;
   logic             xfer;

   assign xfer = bus.s_valid & bus.s_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         widx          <= '0;
         remaining     <= '0;
         bus.s_ready   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_waddr <= '0;
         bus.mem_wdata <= '0;
         cpu_stall     <= HOLD_AT_RESET;
         pc_reset      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         bus.mem_we <= 1'b0;
         pc_reset   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_words > DEPTH_C) begin
                     err <= 1'b1;
                  end else if (num_words == '0) begin
                     state     <= RELEASE;
                     busy      <= 1'b1;
                     cpu_stall <= 1'b1;
                     pc_reset  <= 1'b1;
                     done      <= 1'b1;
                  end else begin
                     state       <= LOAD;
                     busy        <= 1'b1;
                     cpu_stall   <= 1'b1;
                     bus.s_ready <= 1'b1;
                     remaining   <= num_words;
                     widx        <= '0;
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_waddr <= 32'({widx, 2'b00});
                  bus.mem_wdata <= bus.s_data;
                  widx          <= widx + 1'b1;
                  remaining     <= remaining - 1'b1;
                  // Release is raised together with the last write, never before it.
                  if (remaining == CNT_W'(1)) begin
                     state       <= RELEASE;
                     bus.s_ready <= 1'b0;
                     pc_reset    <= 1'b1;
                     done        <= 1'b1;
                  end
               end
            end
            RELEASE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cpu_stall <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               busy        <= 1'b0;
               bus.s_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed-plus-random bench for imem_boot_loader against a word-list model.
module tb_imem_boot_loader;
   localparam int DEPTH = 64;
   localparam int NW_W  = $clog2(DEPTH) + 1;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic [NW_W-1:0] num_words = '0;
   logic            cpu_stall, pc_reset, busy, done, err;

   imem_boot_loader_if bus();

   imem_boot_loader #(.DEPTH(DEPTH), .HOLD_AT_RESET(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_words (num_words),
      .bus       (bus),
      .cpu_stall (cpu_stall),
      .pc_reset  (pc_reset),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int seen_writes = 0;
   int seen_dones  = 0;
   int m_writes = 0;
   int m_dones  = 0;

   logic        m_ready, m_we, m_stall, m_pc, m_busy, m_done, m_err;
   logic [31:0] m_addr, m_data;
   logic [31:0] fixed_words[$];
   bit          vpat[$];

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) seen_writes++;
      if (done === 1'b1) seen_dones++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, ".s_ready"},   32'(bus.s_ready), 32'(m_ready));
      chk({tag, ".mem_we"},    32'(bus.mem_we),  32'(m_we));
      if (m_we) begin
         chk({tag, ".mem_waddr"}, bus.mem_waddr, m_addr);
         chk({tag, ".mem_wdata"}, bus.mem_wdata, m_data);
      end
      chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(m_stall));
      chk({tag, ".pc_reset"},  32'(pc_reset),  32'(m_pc));
      chk({tag, ".busy"},      32'(busy),      32'(m_busy));
      chk({tag, ".done"},      32'(done),      32'(m_done));
      chk({tag, ".err"},       32'(err),       32'(m_err));
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_ready = 1'b0; m_we = 1'b0; m_stall = 1'b1; m_pc = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
   endtask

   // Expected writes are word i at byte address 4*i, in stream order.
   task automatic run_load(input int n, input int pct, input bit glitch);
      logic [31:0] words[$];
      int idx   = 0;
      int guard = 0;
      for (int i = 0; i < n; i++)
         words.push_back((fixed_words.size() == n) ? fixed_words[i] : $urandom);
      start = 1'b1; num_words = NW_W'(n);
      tick();
      start = 1'b0;
      m_err = 1'b0; m_we = 1'b0; m_busy = 1'b1; m_stall = 1'b1;
      if (n == 0) begin
         m_ready = 1'b0; m_pc = 1'b1; m_done = 1'b1; m_dones++;
         chk_outs("zero_release");
      end else begin
         m_ready = 1'b1; m_pc = 1'b0; m_done = 1'b0;
         chk_outs("load_entry");
         while (idx < n && guard < 2000) begin
            bit v;
            if (vpat.size() > 0) v = vpat[guard % vpat.size()];
            else v = (($urandom % 100) < pct);
            bus.s_valid = v;
            bus.s_data  = v ? words[idx] : $urandom;
            if (glitch && guard == 1) begin start = 1'b1; num_words = NW_W'(DEPTH + 1); end
            if (glitch && guard == 2) begin start = 1'b1; num_words = NW_W'(1); end
            tick();
            start = 1'b0;
            guard++;
            m_we = v;
            if (v) begin
               m_addr = 32'(idx * 4); m_data = words[idx]; idx++; m_writes++;
               if (idx == n) begin
                  m_ready = 1'b0; m_pc = 1'b1; m_done = 1'b1; m_dones++;
               end
            end
            chk_outs("load");
         end
         bus.s_valid = 1'b0;
         if (guard >= 2000) chk("load_bound", 32'(idx), 32'(n));
      end
      tick();
      m_we = 1'b0; m_pc = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_stall = 1'b0; m_ready = 1'b0;
      chk_outs("idle_after");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      model_reset();

      // Reset and stalled idle
      #1 rst_n = 1'b0;
      tick(); tick();
      chk_outs("reset");
      chk("reset.mem_waddr", bus.mem_waddr, 32'h0);
      chk("reset.mem_wdata", bus.mem_wdata, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.s_valid = 1'b1; bus.s_data = $urandom;
         tick();
         chk_outs("idle_hold");
      end
      bus.s_valid = 1'b0;

      // Oversized request rejected, stall untouched
      start = 1'b1; num_words = NW_W'(DEPTH + 1);
      tick();
      start = 1'b0;
      m_err = 1'b1;
      chk_outs("err_pulse");
      tick();
      m_err = 1'b0;
      chk_outs("err_clear");

      // Fixed program back-to-back, then with gaps in s_valid
      fixed_words.push_back(32'h00500093);
      fixed_words.push_back(32'h00100113);
      fixed_words.push_back(32'h002081B3);
      fixed_words.push_back(32'h0000006F);
      run_load(4, 100, 1'b0);
      vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b0);
      vpat.push_back(1'b1); vpat.push_back(1'b1); vpat.push_back(1'b0);
      vpat.push_back(1'b1);
      run_load(4, 0, 1'b0);
      vpat.delete();
      fixed_words.delete();

      // Full-depth load, empty load, load with start pulses during LOAD
      run_load(DEPTH, 75, 1'b0);
      run_load(0, 100, 1'b0);
      run_load(8 + int'($urandom % 20), 60, 1'b1);

      // Reset after two of four words
      start = 1'b1; num_words = NW_W'(4);
      tick();
      start = 1'b0;
      bus.s_valid = 1'b1; bus.s_data = 32'hA5A5_0001;
      tick();
      bus.s_data = 32'hA5A5_0002;
      m_ready = 1'b1; m_we = 1'b1; m_addr = 32'h0; m_data = 32'hA5A5_0001;
      m_stall = 1'b1; m_busy = 1'b1; m_pc = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_writes++;
      chk_outs("partial0");
      tick();
      bus.s_valid = 1'b0;
      m_addr = 32'h4; m_data = 32'hA5A5_0002;
      m_writes++;
      chk_outs("partial1");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_outs("async_reset");
      chk("async_reset.mem_waddr", bus.mem_waddr, 32'h0);
      chk("async_reset.mem_wdata", bus.mem_wdata, 32'h0);
      tick();
      chk_outs("reset_hold");
      rst_n = 1'b1;
      tick();
      chk_outs("reset_idle");
      run_load(4, 100, 1'b0);

      tick();
      chk("total_writes", 32'(seen_writes), 32'(m_writes));
      chk("total_dones",  32'(seen_dones),  32'(m_dones));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
